// File: rtl/alu_pkg.sv
// alu_pkg: op codes, flag bit positions and shared decode helpers for alu_pipe.
package alu_pkg;
    localparam int OP_W   = 4;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_ANDN = 4'b0100,
        OP_ORN  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010
    } op_e;

    // 01xx codes run B inverted with carry-in 1; SLTU needs the same subtraction
    function automatic logic inv_b(input logic [OP_W-1:0] op);
        return op[3:2] == 2'b01 || op == OP_SLTU;
    endfunction
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation request and result handshake bundle for alu_pipe.
interface alu_pipe_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_flags;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath producing result and {carry, overflow, zero}.
// Shift ops exist only when ALU_PIPE_SHIFT_EN is defined; otherwise those codes are illegal.
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);
`ifdef ALU_PIPE_SHIFT_EN
    localparam int SW = $clog2(WIDTH);
`endif
    logic             inv, carry, ovf, arith;
    logic [WIDTH-1:0] bx, sum;

    always_comb begin
        inv = inv_b(op);
        bx = inv ? ~b : b;
        {carry, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, inv};
        ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        arith = op == OP_ADD || op == OP_SUB;
        result = '0;
        case (op_e'(op))
            OP_AND, OP_ANDN: result = a & bx;
            OP_OR, OP_ORN:   result = a | bx;
            OP_ADD, OP_SUB:  result = sum;
            OP_SLT:          result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            OP_SLTU:         result = {{(WIDTH-1){1'b0}}, !carry};
`ifdef ALU_PIPE_SHIFT_EN
            OP_SLL:          result = a << b[SW-1:0];
            OP_SRL:          result = a >> b[SW-1:0];
            OP_SRA:          result = $signed(a) >>> b[SW-1:0];
`endif
            default:         result = '0;
        endcase
        flags = '0;
        flags[FLAG_C] = arith && carry;
        flags[FLAG_V] = arith && ovf;
        flags[FLAG_Z] = result == '0;
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline (operand register, then result register).
// Shift ops are built only when ALU_PIPE_SHIFT_EN is defined.
module alu_pipe import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, core_res;
    logic [OP_W-1:0]  op_q, op_d;
    logic [2:0]       flags_q, flags_d, core_flags;
    logic             s2_adv, in_ready, fire, load_s2;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a(a_q), .b(b_q), .op(op_q), .result(core_res), .flags(core_flags)
    );

    // S2 frees up when empty or draining, which in turn lets S1 take a new op
    always_comb begin
        s2_adv = !s2_valid_q || bus.out_ready;
        in_ready = !s1_valid_q || s2_adv;
        fire = bus.in_valid && in_ready;
        load_s2 = s1_valid_q && s2_adv;
        s1_valid_d = in_ready ? bus.in_valid : s1_valid_q;
        a_d = fire ? bus.in_a : a_q;
        b_d = fire ? bus.in_b : b_q;
        op_d = fire ? bus.in_op : op_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        res_d = load_s2 ? core_res : res_q;
        flags_d = load_s2 ? core_flags : flags_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            res_q <= '0;
            flags_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            a_q <= a_d;
            b_q <= b_d;
            op_q <= op_d;
            res_q <= res_d;
            flags_q <= flags_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_result = res_q;
    assign bus.out_flags = flags_q;
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 4..64, power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation offered.
REQ-005 SHALL have port in_ready  output  1  operation accepted when in_valid & in_ready.
REQ-006 SHALL have port in_a  input  WIDTH  operand A.
REQ-007 SHALL have port in_b  input  WIDTH  operand B (shift amount in low log2(WIDTH) bits for shifts).
REQ-008 SHALL have port in_op  input  4  operation code (encoding REQ-014).
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result when out_valid & out_ready.
REQ-011 SHALL have port out_result  output  WIDTH  result.
REQ-012 SHALL have port out_flags  output  3  {carry, overflow, zero}.

Function
REQ-013 SHALL be a two-stage pipeline: S1 registers accepted {a,b,op}; S2 registers computed result and flags; latency exactly 2 cycles from accept to out_valid with no backpressure.
REQ-014 SHALL decode in_op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0011 SLTU, 0100 ANDN (a&~b), 0101 ORN (a|~b), 1000 SLL, 1001 SRL, 1010 SRA; bit 2 inverts B and forces carry-in 1 for 01xx arithmetic/logic codes.
REQ-015 SHALL treat any other code as illegal: result 0, flags {0,0,1}.
REQ-016 SHALL compute ADD/SUB modulo 2^WIDTH; carry = carry-out of a + (b^inv) + inv; overflow = signed overflow; both 0 for all non-ADD/SUB ops.
REQ-017 SHALL produce SLT/SLTU as 1 in bit 0, zeros elsewhere; SLT = sign(a-b) xor overflow(a-b); SLTU = a<b unsigned.
REQ-018 SHALL set zero = (out_result == 0) for every op.
REQ-019 SHALL stall S2 while out_valid & !out_ready, holding out_result/out_flags stable.
REQ-020 SHALL advance S1 into S2 when S2 is empty or draining the same cycle; in_ready = !S1_valid | S1 advancing (full throughput, one op per cycle under continuous out_ready).
REQ-021 SHALL accept a new op and drain S2 in the same cycle without loss or duplication; order preserved.
REQ-022 SHALL ignore in_a/in_b/in_op when in_valid is low or in_ready is low.

Reset
REQ-023 SHALL on rst clear S1_valid and S2_valid immediately (asynchronous); out_valid=0, out_result=0, out_flags=0, in_ready=1 after release.
REQ-024 SHALL discard any in-flight operations on reset mid-operation; no result emitted for them.

Configuration
REQ-025 SHALL compile shift ops (1000, 1001, 1010) only when macro ALU_PIPE_SHIFT_EN is defined; without it these codes are illegal per REQ-015 and no shifter logic exists.

Structure
REQ-026 SHALL place op-code localparams, flag bit indices and an op enum typedef in shared package alu_pkg.
REQ-027 SHALL place the combinational datapath (REQ-014..018) in sub-module alu_core, parameterised by WIDTH, instantiated between S1 and S2.

Verification
REQ-028 WIDTH=8, ADD a=0x7F b=0x01, out_ready=1 -> 2 cycles later result 0x80, flags {0,1,0}.
REQ-029 WIDTH=8, SUB a=0x05 b=0x05 -> result 0x00, flags {1,0,1}; SLT a=0xFF b=0x01 -> 0x01; SLTU same operands -> 0x00.
REQ-030 Back-to-back 4 ops with out_ready=1 -> 4 results on consecutive cycles, in order, in_ready never low.
REQ-031 out_ready=0 for 5 cycles with continuous in_valid -> exactly 2 ops accepted, in_ready low after, out_result stable; release -> remaining ops flow in order.
REQ-032 With ALU_PIPE_SHIFT_EN: SRA a=0x90 b=0x02 -> 0xE4; without it same op -> 0x00, flags {0,0,1}.
REQ-033 rst asserted while S1 and S2 hold valid ops -> out_valid drops asynchronously, no stale result appears after release.
